ps2_mouse_tracker: RTL and testbench
====================================

# ps2_mouse_tracker

Receive-only PS/2 mouse front end that turns the raw PS/2 clock/data line pair into the absolute cursor position and button state used by the display controller. It sits directly upstream of the display controller and drives its `mouseX`/`mouseY` inputs in 4×4-pixel cell units, 160×120 grid. Each 3-byte stream-mode packet is decoded, its signed deltas are applied to the current position, and the result is clamped to the screen. Sending the stream-enable command (0xF4) is out of scope and belongs to a separate block.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 100000: idle clk50 cycles (2 ms) after which a partial frame or packet is abandoned.
- `X_MAX`, 159: largest legal `mouseX`.
- `Y_MAX`, 119: largest legal `mouseY`.
- `X_INIT`, 80: reset value of `mouseX`.
- `Y_INIT`, 60: reset value of `mouseY`.
- `MOVE_SHIFT`, 0: arithmetic right shift applied to each delta (sensitivity).

Ports:
- `clk50` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `ps2Clk` in 1: raw PS/2 clock, asynchronous to clk50.
- `ps2Data` in 1: raw PS/2 data, asynchronous to clk50.
- `mouseX` out 10: cursor column, 0..X_MAX.
- `mouseY` out 10: cursor row, 0..Y_MAX. Screen-down is positive.
- `btnLeft`, `btnRight`, `btnMiddle` out 1 each: button state from the last valid packet.
- `packetValid` out 1: one-cycle pulse when the position and button outputs update.
- `frameError` out 1: one-cycle pulse on a parity, stop-bit or timeout error.

## Operation
- **Synchronisers:** `ps2Clk` and `ps2Data` each pass through a 2-flop synchroniser. A third flop on the clock path provides falling-edge detection: previous value 1 and current value 0 marks a sample cycle, and data is sampled in that cycle.
- **Frame FSM states:**
  - IDLE: a sampled 0 starts a frame and moves to DATA; a sampled 1 is ignored.
  - DATA: receives 8 bits, LSB first.
  - PARITY: the frame is good only if the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - STOP: the stop bit must be 1. A good frame raises a byte strobe. A bad parity or stop bit pulses `frameError`, discards the byte and returns to IDLE.
- **Timeout:** the timeout counter clears on every sample cycle and saturates otherwise.
  - In any non-IDLE state, reaching TIMEOUT_CYCLES forces IDLE and pulses `frameError`.
  - In IDLE with a packet partly assembled, reaching TIMEOUT_CYCLES silently resets the packet index to 0.
- **Packet assembler:** tracks the byte index 0..2.
  - Byte 0 is accepted only if bit3 = 1; otherwise it is dropped silently and the index stays 0 (resync).
  - Byte 0 fields: bit0 L, bit1 R, bit2 M, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
  - dx = {Xsign, byte1} and dy = {Ysign, byte2}, each 9-bit two's complement.
  - Any `frameError` resets the index to 0.
- **Update**, performed on acceptance of byte 2:
  - An axis whose overflow bit is set uses a delta of 0.
  - Each delta is shifted right arithmetically by MOVE_SHIFT.
  - newX = clamp(mouseX + dx, 0, X_MAX); newY = clamp(mouseY − dy, 0, Y_MAX). The Y subtraction converts PS/2 up-positive to screen down-positive.
  - Intermediates are 12-bit signed. Clamping happens in the same cycle, so no out-of-range value is ever driven.
  - Buttons update in the same cycle as the position.
- **Reset values:** `mouseX` = X_INIT, `mouseY` = Y_INIT, all buttons 0, both pulses 0. The FSM returns to IDLE, the packet index to 0 and the timeout counter to 0. Reset asserted mid-frame discards the partial frame immediately.

## Timing
- A pin falling edge is detected 3 clk50 edges later (2 sync flops plus the edge flop). Call the detection cycle D.
- The stop-bit sample happens at D. The byte strobe is registered at D+1.
- For byte 2, the outputs and `packetValid` are registered at D+2. `packetValid` is high for exactly cycle D+2.
- `frameError` is high for exactly one cycle, at D+1 for a parity or stop-bit error, or in the cycle after the timeout hits.
- Outputs are stable between packets; the display controller may sample them in any cycle.
- Throughput: one packet per 33 PS/2 clocks; no backpressure.

## Structure
- Shared package `ps2_pkg` holds:
  - the frame FSM state encoding (IDLE/DATA/PARITY/STOP);
  - byte-0 bit-position constants;
  - the frame length constant (11).
- Sub-module `ps2_rx_byte` contains the synchronisers, edge detect, frame FSM and timeout logic. Its outputs are `byteData[7:0]`, `byteStrobe`, `frameError` and `idleTimeout`.
- Top-level `ps2_mouse_tracker` contains the packet assembler, delta arithmetic and clamping.

## Test plan
- Reset → `mouseX`=80, `mouseY`=60, buttons 0, no pulses.
- Packet 0x09,0x05,0x03 → `mouseX`=85, `mouseY`=57, `btnLeft`=1, and `packetValid` pulses exactly once, 2 cycles after byte-2 stop detection.
- Packet 0x38,0x9C,0x10 (dx=−100, dy=−240) → `mouseX` clamps to 0, `mouseY` clamps to 119.
- Packet 0x48,0x10,0x00 (X overflow) → `mouseX` unchanged, `mouseY` unchanged, `packetValid` pulses.
- Byte 1 sent with bad parity → `frameError` pulses and outputs are unchanged. A following good packet 0x08,0x01,0x00 → `mouseX`+1.
- Stray byte 0x00, then packet 0x08,0x01,0x00 → the stray byte is dropped and `mouseX`+1.
- 5 bits sent, then a stall longer than TIMEOUT_CYCLES → `frameError` pulses. The next full packet then decodes correctly.
- `rst` asserted mid-frame → all outputs take their reset values asynchronously, and the next packet decodes correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path:
// frame FSM states, byte-0 field positions, frame length, clamp helper.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_e;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;
    localparam int DATA_BITS  = FRAME_BITS - 3;

    // Byte 0 of a stream-mode packet
    localparam int B0_LEFT   = 0;
    localparam int B0_RIGHT  = 1;
    localparam int B0_MIDDLE = 2;
    localparam int B0_SYNC   = 3;
    localparam int B0_XSIGN  = 4;
    localparam int B0_YSIGN  = 5;
    localparam int B0_XOVF   = 6;
    localparam int B0_YOVF   = 7;

    // Clamp a signed 12-bit coordinate into 0..maxv.
    function automatic logic [9:0] clamp_axis(
        input logic signed [11:0] v,
        input int unsigned        maxv
    );
        logic signed [11:0] lim;
        lim = $signed(12'(maxv));
        if (v < 12'sd0)
            return 10'd0;
        else if (v > lim)
            return 10'(maxv);
        else
            return v[9:0];
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 byte receiver: synchronisers, falling-edge detect, 11-bit frame FSM
// and idle timeout.
// Ports: clk50/rst, raw ps2Clk/ps2Data in; byteData/byteStrobe for each good
// frame, frameError pulse on parity/stop/timeout, idleTimeout level while
// the line has been quiet for TIMEOUT_CYCLES in IDLE.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [7:0] byteData,
    output logic       byteStrobe,
    output logic       frameError,
    output logic       idleTimeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

    logic [2:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          sample;
    logic          sdata;
    logic          tmo_hit;

    frame_state_e  state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic          par_ok_q;
    logic [TW-1:0] tmo_cnt_q;
    logic [7:0]    byte_q;
    logic          strobe_q;
    logic          err_q;
    logic          idle_to_q;

    // clk_sync_q[2] is the edge flop behind the 2-flop synchroniser
    assign sample  = clk_sync_q[2] & ~clk_sync_q[1];
    assign sdata   = dat_sync_q[1];
    assign tmo_hit = (tmo_cnt_q == TMO);

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            clk_sync_q <= 3'b111;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[1:0], ps2Clk};
            dat_sync_q <= {dat_sync_q[0], ps2Data};
        end
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            par_ok_q  <= 1'b0;
            tmo_cnt_q <= '0;
            byte_q    <= '0;
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            idle_to_q <= 1'b0;
        end else begin
            strobe_q  <= 1'b0;
            err_q     <= 1'b0;
            idle_to_q <= (state_q == ST_IDLE) && tmo_hit;

            if (sample)
                tmo_cnt_q <= '0;
            else if (!tmo_hit)
                tmo_cnt_q <= tmo_cnt_q + 1'b1;

            if (tmo_hit && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                err_q   <= 1'b1;
            end else if (sample) begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (!sdata) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                            par_q     <= 1'b0;
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {sdata, shift_q[7:1]};
                        par_q     <= par_q ^ sdata;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'(DATA_BITS - 1))
                            state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        // odd parity over data + parity bit
                        par_ok_q <= par_q ^ sdata;
                        state_q  <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (sdata && par_ok_q) begin
                            byte_q   <= shift_q;
                            strobe_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign byteData    = byte_q;
    assign byteStrobe  = strobe_q;
    assign frameError  = err_q;
    assign idleTimeout = idle_to_q;

endmodule

// File: rtl/ps2_mouse_tracker.sv
// PS/2 mouse tracker: assembles 3-byte stream packets and keeps a clamped
// absolute cursor position in 4x4-pixel cells plus button state.
// Ports: clk50/rst, raw ps2Clk/ps2Data in; mouseX/mouseY, btnLeft/Right/
// Middle, packetValid pulse on update, frameError pulse on receive error.
module ps2_mouse_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned X_MAX          = 159,
    parameter int unsigned Y_MAX          = 119,
    parameter int unsigned X_INIT         = 80,
    parameter int unsigned Y_INIT         = 60,
    parameter int unsigned MOVE_SHIFT     = 0
) (
    input  logic       clk50,
    input  logic       rst,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic [9:0] mouseX,
    output logic [9:0] mouseY,
    output logic       btnLeft,
    output logic       btnRight,
    output logic       btnMiddle,
    output logic       packetValid,
    output logic       frameError
);

    logic [7:0] rx_byte;
    logic       rx_strobe;
    logic       rx_err;
    logic       rx_idle_to;

    ps2_rx_byte #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk50      (clk50),
        .rst        (rst),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .byteData   (rx_byte),
        .byteStrobe (rx_strobe),
        .frameError (rx_err),
        .idleTimeout(rx_idle_to)
    );

    logic [1:0] idx_q;
    logic [7:0] b0_q;
    logic [7:0] b1_q;
    logic [9:0] x_q, y_q;
    logic       bl_q, br_q, bm_q;
    logic       pv_q;

    logic signed [11:0] dx, dy, nx, ny;
    logic [9:0]         x_d, y_d;

    // Deltas use byte 0/1 from registers and byte 2 straight off the strobe
    always_comb begin
        dx = {{3{b0_q[B0_XSIGN]}}, b0_q[B0_XSIGN], b1_q};
        dy = {{3{b0_q[B0_YSIGN]}}, b0_q[B0_YSIGN], rx_byte};
        if (b0_q[B0_XOVF])
            dx = '0;
        if (b0_q[B0_YOVF])
            dy = '0;
        dx  = dx >>> MOVE_SHIFT;
        dy  = dy >>> MOVE_SHIFT;
        nx  = $signed({2'b00, x_q}) + dx;
        ny  = $signed({2'b00, y_q}) - dy;
        x_d = clamp_axis(nx, X_MAX);
        y_d = clamp_axis(ny, Y_MAX);
    end

    always_ff @(posedge clk50 or posedge rst) begin
        if (rst) begin
            idx_q <= 2'd0;
            b0_q  <= '0;
            b1_q  <= '0;
            x_q   <= 10'(X_INIT);
            y_q   <= 10'(Y_INIT);
            bl_q  <= 1'b0;
            br_q  <= 1'b0;
            bm_q  <= 1'b0;
            pv_q  <= 1'b0;
        end else begin
            pv_q <= 1'b0;
            if (rx_err || rx_idle_to) begin
                idx_q <= 2'd0;
            end else if (rx_strobe) begin
                unique case (idx_q)
                    2'd0: begin
                        // bytes without the sync bit are dropped to resync
                        if (rx_byte[B0_SYNC]) begin
                            b0_q  <= rx_byte;
                            idx_q <= 2'd1;
                        end
                    end
                    2'd1: begin
                        b1_q  <= rx_byte;
                        idx_q <= 2'd2;
                    end
                    default: begin
                        x_q   <= x_d;
                        y_q   <= y_d;
                        bl_q  <= b0_q[B0_LEFT];
                        br_q  <= b0_q[B0_RIGHT];
                        bm_q  <= b0_q[B0_MIDDLE];
                        pv_q  <= 1'b1;
                        idx_q <= 2'd0;
                    end
                endcase
            end
        end
    end

    assign mouseX      = x_q;
    assign mouseY      = y_q;
    assign btnLeft     = bl_q;
    assign btnRight    = br_q;
    assign btnMiddle   = bm_q;
    assign packetValid = pv_q;
    assign frameError  = rx_err;

endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// Directed bench for ps2_mouse_tracker: drives PS/2 frames bit by bit and
// checks position, buttons and pulse counts against hand-computed values.
module tb_ps2_mouse_tracker;

    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic       clk50 = 1'b0;
    logic       rst;
    logic       ps2Clk;
    logic       ps2Data;
    logic [9:0] mouseX, mouseY;
    logic       btnLeft, btnRight, btnMiddle;
    logic       packetValid, frameError;

    int n_chk = 0;
    int n_fail = 0;
    int pv_cnt = 0;
    int fe_cnt = 0;

    ps2_mouse_tracker #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk50      (clk50),
        .rst        (rst),
        .ps2Clk     (ps2Clk),
        .ps2Data    (ps2Data),
        .mouseX     (mouseX),
        .mouseY     (mouseY),
        .btnLeft    (btnLeft),
        .btnRight   (btnRight),
        .btnMiddle  (btnMiddle),
        .packetValid(packetValid),
        .frameError (frameError)
    );

    always #10 clk50 = ~clk50;

    always @(posedge clk50) begin
        if (packetValid) pv_cnt++;
        if (frameError)  fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk50);
        ps2Data = b;
        repeat (HALF) @(negedge clk50);
        ps2Clk = 1'b0;
        repeat (HALF) @(negedge clk50);
        ps2Clk = 1'b1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b,
                                          input logic bad_par);
        logic p;
        p = ~^b ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par,
                             input int nbits);
        logic [10:0] f;
        f = frame(b, bad_par);
        for (int i = 0; i < nbits; i++)
            ps2_bit(f[i]);
        repeat (5) @(negedge clk50);
    endtask

    task automatic send_pkt(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c);
        send_byte(a, 1'b0, 11);
        send_byte(b, 1'b0, 11);
        send_byte(c, 1'b0, 11);
    endtask

    task automatic check_out(input string tag, input int x, input int y,
                             input logic l, input logic r, input logic m);
        check({tag, ".x"}, 32'(mouseX), 32'(x));
        check({tag, ".y"}, 32'(mouseY), 32'(y));
        check({tag, ".l"}, 32'(btnLeft), 32'(l));
        check({tag, ".r"}, 32'(btnRight), 32'(r));
        check({tag, ".m"}, 32'(btnMiddle), 32'(m));
    endtask

    int pv0, fe0;

    initial begin
        rst     = 1'b1;
        ps2Clk  = 1'b1;
        ps2Data = 1'b1;
        repeat (4) @(negedge clk50);
        check_out("reset", 80, 60, 0, 0, 0);
        check("reset.pv", 32'(packetValid), 0);
        check("reset.fe", 32'(frameError), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk50);

        // Packet 1 with latency check on the final stop bit
        pv0 = pv_cnt;
        send_byte(8'h09, 1'b0, 11);
        send_byte(8'h05, 1'b0, 11);
        send_byte(8'h03, 1'b0, 10);
        @(negedge clk50);
        ps2Data = 1'b1;
        repeat (HALF) @(negedge clk50);
        ps2Clk = 1'b0;
        repeat (3) @(posedge clk50);
        #1 check("p1.pv_early", 32'(packetValid), 0);
        @(posedge clk50);
        #1 check("p1.pv_d2", 32'(packetValid), 1);
        check_out("p1", 85, 57, 1, 0, 0);
        @(posedge clk50);
        #1 check("p1.pv_len", 32'(packetValid), 0);
        repeat (HALF) @(negedge clk50);
        ps2Clk = 1'b1;
        repeat (5) @(negedge clk50);
        check("p1.pv_once", 32'(pv_cnt - pv0), 1);

        // Clamp both axes
        send_pkt(8'h38, 8'h9C, 8'h10);
        check_out("clamp", 0, 119, 0, 0, 0);

        // X overflow: deltas discarded
        pv0 = pv_cnt;
        send_pkt(8'h48, 8'h10, 8'h00);
        check_out("xovf", 0, 119, 0, 0, 0);
        check("xovf.pv", 32'(pv_cnt - pv0), 1);

        // Bad parity on byte 1
        pv0 = pv_cnt;
        fe0 = fe_cnt;
        send_byte(8'h08, 1'b0, 11);
        send_byte(8'h01, 1'b1, 11);
        check("par.fe", 32'(fe_cnt - fe0), 1);
        check("par.pv", 32'(pv_cnt - pv0), 0);
        check("par.x", 32'(mouseX), 0);
        send_pkt(8'h08, 8'h01, 8'h00);
        check_out("par_next", 1, 119, 0, 0, 0);

        // Stray byte without sync bit
        pv0 = pv_cnt;
        send_byte(8'h00, 1'b0, 11);
        send_pkt(8'h08, 8'h01, 8'h00);
        check_out("stray", 2, 119, 0, 0, 0);
        check("stray.pv", 32'(pv_cnt - pv0), 1);

        // Partial frame then stall past the timeout
        fe0 = fe_cnt;
        pv0 = pv_cnt;
        send_byte(8'hFF, 1'b0, 5);
        repeat (TMO + 100) @(negedge clk50);
        check("tmo.fe", 32'(fe_cnt - fe0), 1);
        check("tmo.pv", 32'(pv_cnt - pv0), 0);
        send_pkt(8'h0A, 8'h03, 8'h01);
        check_out("tmo_next", 5, 118, 0, 1, 0);

        // Asynchronous reset mid-frame
        send_byte(8'h55, 1'b0, 3);
        @(negedge clk50);
        #2 rst = 1'b1;
        #1 check_out("arst", 80, 60, 0, 0, 0);
        repeat (3) @(negedge clk50);
        rst = 1'b0;
        repeat (3) @(negedge clk50);
        send_pkt(8'h1C, 8'hFE, 8'h00);
        check_out("arst_next", 78, 60, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
